mips_multicycle_ctrl: RTL

//   Multicycle MIPS main control FSM. Decodes the 6-bit opcode and drives the select lines
//   of the datapath muxes:
//   - pc_source: 4:1 PC mux
//   - alu_src_b: 4:1 ALU-B mux
//   - reg_dst: 5-bit 2:1 write-register mux
//   - alu_src_a, mem_to_reg, iord: 32-bit 2:1 muxes
//   It also drives the register, IR, PC and memory write enables.

---
 rtl/mips_multicycle_ctrl_if.sv | 41 ++++
 rtl/mips_multicycle_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Control-to-datapath bundle for the multicycle MIPS controller.
// The exc line exists only when CTRL_EXCEPTION_EN is defined.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state_o;
`ifdef CTRL_EXCEPTION_EN
    logic       exc;
`endif

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, state_o
`ifdef CTRL_EXCEPTION_EN
        , output exc
`endif
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, state_o
`ifdef CTRL_EXCEPTION_EN
        , input exc
`endif
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM with memory-ready stalls.
// Define CTRL_EXCEPTION_EN to add the EXCEPT state and exc output for undefined opcodes.
module mips_multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mips_multicycle_ctrl_if.master      ctrl
);

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADDR  = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10
`ifdef CTRL_EXCEPTION_EN
        , S_EXCEPT = 4'd11
`endif
    } state_t;

    state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RST;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_RST:      state_nxt = S_FETCH;
            S_FETCH:    state_nxt = ctrl.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (ctrl.opcode == OP_LW || ctrl.opcode == OP_SW) state_nxt = S_MEMADDR;
                else if (ctrl.opcode == OP_RTYPE)                 state_nxt = S_EXECUTE;
                else if (ctrl.opcode == OP_BEQ)                   state_nxt = S_BRANCH;
                else if (ctrl.opcode == OP_J)                     state_nxt = S_JUMP;
`ifdef CTRL_EXCEPTION_EN
                else                                              state_nxt = S_EXCEPT;
`else
                else                                              state_nxt = S_FETCH;
`endif
            end
            // An opcode that is neither LW nor SW here can only come from a corrupted IR; refetch.
            S_MEMADDR: begin
                if (ctrl.opcode == OP_LW)      state_nxt = S_MEMREAD;
                else if (ctrl.opcode == OP_SW) state_nxt = S_MEMWRITE;
                else                           state_nxt = S_FETCH;
            end
            S_MEMREAD:  state_nxt = ctrl.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: state_nxt = ctrl.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_nxt = S_RTYPE_WB;
            S_RTYPE_WB: state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_JUMP:     state_nxt = S_FETCH;
`ifdef CTRL_EXCEPTION_EN
            S_EXCEPT:   state_nxt = S_FETCH;
`endif
            default:    state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl.pc_write   = 1'b0;
        ctrl.ir_write   = 1'b0;
        ctrl.mem_read   = 1'b0;
        ctrl.mem_write  = 1'b0;
        ctrl.iord       = 1'b0;
        ctrl.reg_write  = 1'b0;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = '0;
        ctrl.alu_op     = '0;
        ctrl.pc_source  = '0;
`ifdef CTRL_EXCEPTION_EN
        ctrl.exc        = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.ir_write  = ctrl.mem_ready;
                ctrl.pc_write  = ctrl.mem_ready;
            end
            S_DECODE:   ctrl.alu_src_b = 2'b11;
            S_MEMADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = 2'b10;
            end
            S_RTYPE_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = 2'b01;
                ctrl.pc_source = 2'b01;
                ctrl.pc_write  = ctrl.zero;
            end
            S_JUMP: begin
                ctrl.pc_source = 2'b10;
                ctrl.pc_write  = 1'b1;
            end
`ifdef CTRL_EXCEPTION_EN
            S_EXCEPT: begin
                ctrl.pc_source = 2'b11;
                ctrl.pc_write  = 1'b1;
                ctrl.exc       = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign ctrl.state_o = state;

endmodule
